// File: rtl/board_io_pkg.sv
// Shared constants, types and helpers for the board I/O controller.
// Used by board_io_ctrl and switch_debouncer via import board_io_pkg::*.
package board_io_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int PWM_WIDTH_DEFAULT       = 8;

    // Upper bounds for the duty-slice helper.
    localparam int DUTY_MAX_W = 16;
    localparam int DUTY_BUS_W = 256;

    // Reserved for a register-mapped successor with per-channel LED mode.
    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_PWM   = 2'd1,
        LED_BLINK = 2'd2
    } led_mode_t;

    // Extract channel ch (w bits wide) from a packed duty bus.
    function automatic logic [DUTY_MAX_W-1:0] duty_slice(
        input logic [DUTY_BUS_W-1:0] bus,
        input int unsigned           ch,
        input int unsigned           w
    );
        logic [DUTY_MAX_W-1:0] mask;
        mask = (DUTY_MAX_W'(1) << w) - DUTY_MAX_W'(1);
        return DUTY_MAX_W'(bus >> (ch * w)) & mask;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Single-channel switch synchroniser + debouncer with edge pulses.
// Ports: clk, rst_n (async, active-low), sw_raw in; sw_db, sw_rise, sw_fall out.
module switch_debouncer
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sw_sync;
    logic                   mismatch;
    logic                   accept;

    assign sw_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        mismatch = sw_sync ^ sw_db;
        // The edge on which the count would reach DEBOUNCE_CYCLES.
        accept   = mismatch && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sw_db   <= 1'b0;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            sw_rise <= accept &  sw_sync;
            sw_fall <= accept & ~sw_sync;
            if (!mismatch) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= '0;
                sw_db <= sw_sync;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced switches to GPIO, PWM/blink LED drive.
// Ports: sw_raw -> sw_db/sw_rise/sw_fall; led_* GPIO -> led_pin/led_state.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int SW_CHANNELS     = 1,
    parameter int LED_CHANNELS    = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int PWM_WIDTH       = PWM_WIDTH_DEFAULT,
    parameter int BLINK_DIV_WIDTH = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [SW_CHANNELS-1:0]            sw_raw,
    output logic [SW_CHANNELS-1:0]            sw_db,
    output logic [SW_CHANNELS-1:0]            sw_rise,
    output logic [SW_CHANNELS-1:0]            sw_fall,
    input  logic [LED_CHANNELS-1:0]           led_dout,
    input  logic [LED_CHANNELS-1:0]           led_oe_n,
    input  logic [LED_CHANNELS*PWM_WIDTH-1:0] led_duty,
    input  logic [LED_CHANNELS-1:0]           led_blink,
    output logic [LED_CHANNELS-1:0]           led_pin,
    output logic [LED_CHANNELS-1:0]           led_state
);

    // ---------------- switches ----------------
    for (genvar g = 0; g < SW_CHANNELS; g++) begin : g_sw
        switch_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_raw  (sw_raw[g]),
            .sw_db   (sw_db[g]),
            .sw_rise (sw_rise[g]),
            .sw_fall (sw_fall[g])
        );
    end

    // ---------------- PWM / blink timebase ----------------
    logic [PWM_WIDTH-1:0]       pwm_cnt_q;
    logic [BLINK_DIV_WIDTH-1:0] blink_div_q;
    logic                       blink_phase_q;
    logic                       pwm_wrap;
    logic                       blink_wrap;

    assign pwm_wrap   = &pwm_cnt_q;
    assign blink_wrap = &blink_div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q     <= '0;
            blink_div_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_q + PWM_WIDTH'(1);
            blink_div_q <= blink_div_q + BLINK_DIV_WIDTH'(1);
            if (blink_wrap) begin
                blink_phase_q <= ~blink_phase_q;
            end
        end
    end

    // ---------------- duty latching ----------------
    // Duties only load on the last count of a period so a new value
    // takes effect cleanly at the next period start.
    logic [PWM_WIDTH-1:0] duty_q [LED_CHANNELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LED_CHANNELS; i++) begin
                duty_q[i] <= '0;
            end
        end else if (pwm_wrap) begin
            for (int i = 0; i < LED_CHANNELS; i++) begin
                duty_q[i] <= PWM_WIDTH'(duty_slice(
                    DUTY_BUS_W'(led_duty), i, PWM_WIDTH));
            end
        end
    end

    // ---------------- LED drive ----------------
    logic [LED_CHANNELS-1:0] pwm_on;
    logic [LED_CHANNELS-1:0] led_next;
    logic [LED_CHANNELS-1:0] led_q;

    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < LED_CHANNELS; i++) begin
            // All-ones duty means fully on, not 2^W-1 of 2^W.
            pwm_on[i] = (&duty_q[i]) || (pwm_cnt_q < duty_q[i]);
        end
    end

    always_comb begin
        led_next = ~led_oe_n & led_dout & pwm_on
                 & (~led_blink | {LED_CHANNELS{blink_phase_q}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_next;
        end
    end

    assign led_pin   = led_q;
    assign led_state = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: directed stimulus pushes expected
// values tagged by clock edge; a monitor compares them on the falling edge.
module tb_board_io_ctrl;

    localparam int SWN = 1;
    localparam int LDN = 2;
    localparam int PW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [SWN-1:0]    sw_raw = '0;
    logic [SWN-1:0]    sw_db, sw_rise, sw_fall;
    logic [LDN-1:0]    led_dout = '0;
    logic [LDN-1:0]    led_oe_n = '1;
    logic [LDN*PW-1:0] led_duty = '0;
    logic [LDN-1:0]    led_blink = '0;
    logic [LDN-1:0]    led_pin, led_state;

    board_io_ctrl #(
        .SW_CHANNELS     (SWN),
        .LED_CHANNELS    (LDN),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .PWM_WIDTH       (PW),
        .BLINK_DIV_WIDTH (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .led_dout  (led_dout),
        .led_oe_n  (led_oe_n),
        .led_duty  (led_duty),
        .led_blink (led_blink),
        .led_pin   (led_pin),
        .led_state (led_state)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Signal ids
    localparam int S_DB = 0, S_RISE = 1, S_FALL = 2;
    localparam int S_PIN = 3, S_STATE = 4, S_PIN1 = 5;

    typedef struct {
        int    e;
        int    sig;
        logic  v;
        string name;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int base    = 0;

    function automatic logic sample(int s);
        case (s)
            S_DB:    return sw_db[0];
            S_RISE:  return sw_rise[0];
            S_FALL:  return sw_fall[0];
            S_PIN:   return led_pin[0];
            S_STATE: return led_state[0];
            S_PIN1:  return led_pin[1];
            default: return 1'bx;
        endcase
    endfunction

    // Monitor
    initial begin
        logic got;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].e <= edge_n) begin
                    got = sample(sb[i].sig);
                    n_tests++;
                    if (sb[i].e < edge_n || got !== sb[i].v) begin
                        n_fail++;
                        $display("FAIL %s: got %b want %b (edge %0d, now %0d)",
                                 sb[i].name, got, sb[i].v, sb[i].e, edge_n);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic push_abs(int e, int sig, logic v, string nm);
        exp_t x;
        x.e = e;
        x.sig = sig;
        x.v = v;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic push(int rel, int sig, logic v, string nm);
        push_abs(base + rel, sig, v, $sformatf("%s@%0d", nm, rel));
    endtask

    task automatic wait_pos(int rel);
        while (edge_n < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_after(int rel);
        wait_pos(rel);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Reset held for 3 edges with all outputs checked 0; release at negedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            push_abs(edge_n + k, S_DB,    1'b0, "rst_db");
            push_abs(edge_n + k, S_RISE,  1'b0, "rst_rise");
            push_abs(edge_n + k, S_FALL,  1'b0, "rst_fall");
            push_abs(edge_n + k, S_PIN,   1'b0, "rst_pin");
            push_abs(edge_n + k, S_STATE, 1'b0, "rst_state");
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = edge_n;
    endtask

    function automatic logic pwm_exp(int e);
        if (e <= 16)  return 1'b0;
        if (e <= 64)  return ((e - 17) % 16) < 4;
        if (e <= 96)  return ((e - 65) % 16) < 12;
        if (e <= 128) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        // ---- A: reset with inputs active, then first acceptance ----
        sw_raw = 1'b1;
        led_dout = '1;
        led_oe_n = '0;
        led_duty = {4'd15, 4'd15};
        led_blink = '0;
        do_reset();
        push(9,  S_DB,    1'b0, "a_db");
        push(9,  S_RISE,  1'b0, "a_rise");
        push(10, S_DB,    1'b1, "a_db");
        push(10, S_RISE,  1'b1, "a_rise");
        push(10, S_FALL,  1'b0, "a_fall");
        push(11, S_RISE,  1'b0, "a_rise");
        push(11, S_DB,    1'b1, "a_db");
        push(16, S_PIN,   1'b0, "a_pin");
        push(17, S_PIN,   1'b1, "a_pin");
        push(17, S_STATE, 1'b1, "a_state");
        wait_drain();

        // ---- B: glitch rejection, then rise and fall ----
        sw_raw = 1'b0;
        do_reset();
        for (int e = 4; e <= 20; e++) begin
            push(e, S_DB,   1'b0, "b_glitch_db");
            push(e, S_RISE, 1'b0, "b_glitch_rise");
        end
        push(29, S_DB,   1'b0, "b_db");
        push(30, S_DB,   1'b1, "b_db");
        push(30, S_RISE, 1'b1, "b_rise");
        push(31, S_RISE, 1'b0, "b_rise");
        push(44, S_FALL, 1'b0, "b_fall");
        push(44, S_DB,   1'b1, "b_db");
        push(45, S_FALL, 1'b1, "b_fall");
        push(45, S_RISE, 1'b0, "b_rise");
        push(45, S_DB,   1'b0, "b_db");
        push(46, S_FALL, 1'b0, "b_fall");
        set_after(2);
        sw_raw = 1'b1;
        set_after(7);
        sw_raw = 1'b0;
        set_after(20);
        sw_raw = 1'b1;
        set_after(35);
        sw_raw = 1'b0;
        wait_drain();

        // ---- C: PWM duties, mid-period change, 0 and all-ones ----
        led_duty = {4'd8, 4'd4};
        do_reset();
        for (int e = 1; e <= 144; e++) begin
            push(e, S_PIN, pwm_exp(e), "c_pwm0");
            push(e, S_PIN1, (e >= 17) && (((e - 17) % 16) < 8), "c_pwm1");
        end
        set_after(50);
        led_duty[3:0] = 4'd12;
        set_after(80);
        led_duty[3:0] = 4'd0;
        set_after(112);
        led_duty[3:0] = 4'd15;
        wait_drain();

        // ---- D: blink gating, then output disable ----
        led_duty = {4'd15, 4'd15};
        led_blink = '1;
        led_oe_n = '0;
        do_reset();
        for (int e = 17; e <= 56; e++) begin
            push(e, S_PIN,   ((e - 1) / 8) % 2 == 1, "d_blink");
            push(e, S_STATE, ((e - 1) / 8) % 2 == 1, "d_state");
        end
        push(58, S_PIN,   1'b1, "d_oe_pin");
        push(59, S_PIN,   1'b0, "d_oe_pin");
        push(59, S_STATE, 1'b0, "d_oe_state");
        set_after(58);
        led_oe_n = '1;
        wait_drain();

        // ---- E: async reset mid-period and mid-debounce ----
        led_oe_n = '0;
        led_blink = '0;
        sw_raw = 1'b1;
        do_reset();
        push(19, S_DB,    1'b1, "e_pre_db");
        push(19, S_PIN,   1'b1, "e_pre_pin");
        push(20, S_DB,    1'b0, "e_async_db");
        push(20, S_RISE,  1'b0, "e_async_rise");
        push(20, S_FALL,  1'b0, "e_async_fall");
        push(20, S_PIN,   1'b0, "e_async_pin");
        push(20, S_STATE, 1'b0, "e_async_state");
        set_after(15);
        sw_raw = 1'b0;
        wait_pos(20);
        #1 rst_n = 1'b0;
        wait_drain();
        sw_raw = 1'b1;
        do_reset();
        push(9,  S_DB,   1'b0, "e_re_db");
        push(10, S_DB,   1'b1, "e_re_db");
        push(10, S_RISE, 1'b1, "e_re_rise");
        push(16, S_PIN,  1'b0, "e_re_pin");
        push(17, S_PIN,  1'b1, "e_re_pin");
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised board-level I/O controller between the SoC GPIO bus and FPGA board pins.
- Successor to direct combinational LED/switch hookup. Adds:
  - N-channel switch synchronisation and debouncing, with edge pulses.
  - M-channel LED drive with per-channel PWM brightness and blink mode.
  - Readback of the actual pin state to GPIO din.
- Sits in the FPGA top between pixel_riscv_soc GPIO signals and board pins.

Parameters:
- SW_CHANNELS, 1, number of switch/button inputs.
- LED_CHANNELS, 5, number of LED outputs.
- SYNC_STAGES, 2, synchroniser flops per switch input (min 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a switch change (min 2).
- PWM_WIDTH, 8, PWM counter/duty width in bits.
- BLINK_DIV_WIDTH, 24, blink prescaler width; blink phase toggles on prescaler wrap.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset (see Behaviour)
- sw_raw  input  SW_CHANNELS  asynchronous board switch/button pins
- sw_db  output  SW_CHANNELS  debounced switch levels, to GPIO din
- sw_rise  output  SW_CHANNELS  one-cycle pulse on accepted 0->1 change
- sw_fall  output  SW_CHANNELS  one-cycle pulse on accepted 1->0 change
- led_dout  input  LED_CHANNELS  GPIO dout bits for the LED channels
- led_oe_n  input  LED_CHANNELS  GPIO output-enable, active low
- led_duty  input  LED_CHANNELS*PWM_WIDTH  per-channel duty; channel i at [i*PWM_WIDTH +: PWM_WIDTH]
- led_blink  input  LED_CHANNELS  1 = channel gated by blink phase
- led_pin  output  LED_CHANNELS  LED pin drive
- led_state  output  LED_CHANNELS  registered copy of led_pin, for GPIO din readback

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, all counters 0, all synchroniser flops 0, all latched duties 0, blink phase 0.
- Switch path (per channel):
  - sw_raw passes through a SYNC_STAGES flop chain to give sw_sync.
  - Debounce counter: cleared when sw_sync == sw_db; otherwise increments.
  - On the clock edge where the counter would reach DEBOUNCE_CYCLES: sw_db <= sw_sync, counter <= 0.
  - The matching sw_rise/sw_fall is asserted for exactly that one cycle, registered with sw_db.
  - Latency from a stable raw change to sw_db: SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
  - Any mismatch shorter than DEBOUNCE_CYCLES cycles is discarded (counter clears); no pulse is produced.
  - sw_rise and sw_fall are never both high on the same channel.
- PWM (shared): one free-running counter pwm_cnt of PWM_WIDTH bits.
  - Wraps from all-ones to 0.
  - Period is 2^PWM_WIDTH cycles.
- Duty latching:
  - Each channel's duty_q loads led_duty only on the cycle where pwm_cnt == all-ones.
  - The new duty therefore applies from the next period start.
  - Mid-period changes cause no glitch.
- PWM compare (per channel): pwm_on = (duty_q == all-ones) || (pwm_cnt < duty_q).
  - duty 0: always off.
  - duty all-ones: constantly on, not 2^W-1 of 2^W.
- Blink: prescaler of BLINK_DIV_WIDTH bits, free-running; blink_phase toggles on prescaler wrap. Shared by all channels.
- LED output: led_pin registered (1-cycle latency) = !led_oe_n & led_dout & pwm_on & (!led_blink | blink_phase).
  - led_oe_n high forces led_pin 0.
- Readback: led_state = led_pin (same register value).
- Reset mid-operation:
  - Immediate clear of all state.
  - After release, switches need a full SYNC_STAGES + DEBOUNCE_CYCLES before any 1 appears.
  - The LED stays off until the first duty latch, at the first pwm_cnt all-ones.
- Widths: the debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits and must not overflow.

Decomposition:
- board_io_pkg holds:
  - the duty-slice helper function;
  - default constants (DEBOUNCE_CYCLES_DEFAULT, PWM_WIDTH_DEFAULT);
  - typedef led_mode_t (off/pwm/blink), reserved for a register-mapped successor.
- Sub-module switch_debouncer, single channel: sync chain, counter, sw_db and edge pulses. Instantiated SW_CHANNELS times with generate.
- PWM, blink and LED logic stay in board_io_ctrl.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=8, SYNC_STAGES=2, PWM_WIDTH=4, BLINK_DIV_WIDTH=3.
- Reset: hold rst_n low with sw_raw=1 and led_dout=1 -> all outputs 0; after release, sw_db rises at edge 10, with sw_rise high exactly that cycle.
- Glitch rejection: sw_raw high for 5 cycles, then low -> sw_db stays 0, no pulses; a 1->0 change after acceptance gives sw_fall once at edge 10.
- PWM duty: led_duty=4, oe_n=0, dout=1 -> led_pin high 4 of every 16 cycles. duty=0 -> never high. duty=15 -> always high.
- Mid-period duty change from 4 to 12 at pwm_cnt=2 -> current period still 4 high cycles, next period 12.
- Blink: led_blink=1, duty=15 -> led_pin alternates 8 cycles on, 8 off. Set led_oe_n=1 -> led_pin 0 within 1 cycle, led_state matches.
- Async reset asserted mid-period and mid-debounce -> outputs 0 immediately, no clock needed; counters restart from 0 after release.
